// File: rtl/seg7_scan_display.sv
// Scans a captured 32-bit word as 8 hex digits onto a common-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits, digit 0 never blanked).
module seg7_scan_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        Clk,
    input  logic        rst,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        sel,
    input  logic        hold,
    output logic [6:0]  out7,
    output logic [7:0]  en_out
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic [2:0]    r_digit;
    logic [31:0]   r_snap;
    logic [6:0]    r_out7;
    logic [7:0]    r_en_out;

    logic          w_tick;
    logic          w_wrap;
    logic [CW-1:0] w_div_next;
    logic [2:0]    w_digit_next;
    logic [31:0]   w_snap_next;
    logic [3:0]    w_nibble;
    logic          w_blank;
    logic [6:0]    w_seg;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        w_tick       = (r_div_cnt == LAST);
        w_wrap       = w_tick && (r_digit == 3'd7);
        w_div_next   = w_tick ? '0 : r_div_cnt + CW'(1);
        w_digit_next = w_tick ? r_digit + 3'd1 : r_digit;
        // Snapshot is only replaced on the wrap edge so a frame never mixes two words.
        w_snap_next  = (w_wrap && !hold) ? (sel ? y : x) : r_snap;
        w_nibble     = w_snap_next[{w_digit_next, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank      = (w_digit_next != 3'd0) &&
                       ((w_snap_next >> {w_digit_next, 2'b00}) == 32'h0);
`else
        w_blank      = 1'b0;
`endif
        w_seg        = w_blank ? 7'h7F : enc(w_nibble);
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_digit   <= '0;
            r_snap    <= '0;
            r_out7    <= 7'h40;
            r_en_out  <= 8'hFE;
        end else begin
            r_div_cnt <= w_div_next;
            r_digit   <= w_digit_next;
            r_snap    <= w_snap_next;
            r_out7    <= w_seg;
            r_en_out  <= ~(8'b1 << w_digit_next);
        end
    end

    assign out7   = r_out7;
    assign en_out = r_en_out;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (REFRESH_DIV=4) against a frame-level model.
module tb_seg7_scan_display;

    localparam int RD    = 4;
    localparam int FRAME = 8 * RD;

    logic        Clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic        sel;
    logic        hold;
    logic [6:0]  out7;
    logic [7:0]  en_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: edges since reset release and the word currently on display.
    int          m_k    = 0;
    logic [31:0] m_snap = 32'h0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan_display #(.REFRESH_DIV(RD)) dut (
        .Clk    (Clk),
        .rst    (rst),
        .x      (x),
        .y      (y),
        .sel    (sel),
        .hold   (hold),
        .out7   (out7),
        .en_out (en_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int cur_digit();
        return (m_k / RD) % 8;
    endfunction

    function automatic logic [6:0] exp_seg();
        int d;
        logic [31:0] upper;
        d     = cur_digit();
        upper = m_snap >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && upper == 32'h0) return 7'h7F;
`endif
        return seg_tab[upper[3:0]];
    endfunction

    function automatic logic [7:0] exp_en();
        logic [7:0] e;
        e = 8'hFF;
        e[cur_digit()] = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag);
        logic [7:0] ee;
        logic [6:0] es;
        ee = exp_en();
        es = exp_seg();
        n_assert++;
        assert (en_out === ee) else begin
            n_fail++;
            $error("FAIL %s en_out: got %h expected %h (k=%0d)", tag, en_out, ee, m_k);
        end
        n_assert++;
        assert (out7 === es) else begin
            n_fail++;
            $error("FAIL %s out7: got %h expected %h (k=%0d snap=%h)", tag, out7, es, m_k, m_snap);
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge Clk);
        if (!rst) begin
            m_k++;
            if (m_k % FRAME == 0 && !hold) m_snap = sel ? y : x;
        end
        #1 chk(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        rst = 1'b0; x = 32'h0; y = 32'h0; sel = 1'b0; hold = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_async");
        run(3, "reset_held");
        @(negedge Clk) rst = 1'b0;
        #1 chk("reset_release");

        // First frame after reset shows the reset snapshot (all zeros); then the word.
        x = 32'h0123_4567;
        run(2 * FRAME, "scan_order");

        y = 32'hDEAD_BEEF;
        run(10, "sel_pre");
        sel = 1'b1;
        run(FRAME, "sel_wrap");

        hold = 1'b1;
        sel  = 1'b0;
        x    = 32'hFFFF_FFFF;
        run(FRAME + 4, "hold_on");
        hold = 1'b0;
        run(FRAME + 4, "hold_off");

        // Async reset between edges while digit 5 is lit.
        for (int i = 0; i < 2 * FRAME && cur_digit() != 5; i++) cyc("seek_d5");
        n_assert++;
        assert (cur_digit() == 5) else begin
            n_fail++;
            $error("FAIL seek_d5: got digit %0d expected 5", cur_digit());
        end
        #2 rst = 1'b1;
        m_k = 0;
        m_snap = 32'h0;
        #1 chk("reset_mid");
        run(2, "reset_mid_held");
        @(negedge Clk) rst = 1'b0;
        run(FRAME + 8, "restart");

        x = 32'h0000_00A5;
        run(2 * FRAME, "blank");
        x = 32'h0000_0000;
        run(2 * FRAME, "all_zero");

        // Random traffic: x/y/sel/hold churn every cycle, only wrap edges may capture.
        for (int i = 0; i < 20 * FRAME; i++) begin
            x    = $urandom() >> $urandom_range(0, 31);
            y    = $urandom() >> $urandom_range(0, 31);
            sel  = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0);
            cyc("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
